ex_mdu: RTL
===========

# ex_mdu

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline. It sits beside the ALU, upstream of the EX/MEM pipeline register. It accepts mult/multu/div/divu/mthi/mtlo requests from the instruction currently in EX and holds the architectural HI and LO registers. mfhi/mflo read HI and LO through the ALUout path into EX/MEM. While an operation is in flight it raises busy, so the hazard unit can stall any later MDU instruction in D.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high
- start  in  1  request valid for the instruction in EX, one cycle per request
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 reserved (ignored)
- A  in  32  rs operand (forwarded value)
- B  in  32  rt operand (forwarded value)
- busy  out  1  operation in flight
- HI  out  32  architectural HI
- LO  out  32  architectural LO

## Operation
- Registers: HI, LO, busy, cycle counter cnt (5 bits), latched op_r, A_r, B_r.
- States:
  - IDLE (busy=0)
  - RUN (busy=1, cnt counts down to 1)
- IDLE with start=1 and op∈{0..3}:
  - latch op, A and B
  - load cnt with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3)
  - go to RUN
- IDLE with start=1 and op=4: HI←A at the edge; busy stays 0.
- IDLE with start=1 and op=5: LO←A at the edge; busy stays 0.
- IDLE with start=1 and op 6/7: no effect.
- RUN with cnt>1: cnt←cnt−1.
- RUN with cnt==1:
  - write the result into HI/LO
  - busy←0, return to IDLE
- Arithmetic, all on the latched operands:
  - mult: {HI,LO} = signed 32×32 → 64-bit product
  - multu: {HI,LO} = unsigned product
  - div: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend
  - divu: LO = unsigned quotient, HI = unsigned remainder
- Boundary rules:
  - Divide by zero (B_r==0): full DIV_CYCLES busy period, then HI and LO remain unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - start while busy=1: ignored, including mthi/mtlo. The hazard unit must stall the requester, so this is a protocol violation, not a queue.
  - Operands are sampled only at acceptance. Later changes on A/B during RUN have no effect.
- Hazard contract: the stall condition for an MDU instruction (including mfhi/mflo) in D is (busy | start). The unit does not see pipeline flushes. An accepted operation always completes.
- Implementation may compute the result at acceptance and delay the write-back, or iterate. Visible timing must match this section either way.

## Timing
- Reset (async, immediate): HI=0, LO=0, busy=0, cnt=0, state IDLE.
- Reset asserted mid-RUN aborts the operation; HI/LO read 0 after reset.
- Accept at edge T0: busy=1 from T0 through the edge T0+N, where N = MULT_CYCLES or DIV_CYCLES.
  - At edge T0+N: HI/LO take the new result and busy falls to 0.
  - busy is high for exactly N cycles.
- A new start sampled at edge T0+N is ignored, since busy=1 before that edge. The earliest next accept is edge T0+N+1.
- mthi/mtlo latency: visible on HI/LO one edge after acceptance.
- HI/LO outputs are registers with no combinational bypass. An mfhi in EX on the cycle of a write edge reads the old value; the hazard stall prevents this case.

## Test plan
- Reset during a run: mult 7×9 accepted, reset asserted 2 cycles later → busy=0 immediately, HI=LO=0, no write at the original completion edge.
- Signed mult: A=0xFFFFFFFE (−2), B=3, op=0 → busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu: A=B=0xFFFFFFFF, op=1 → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- Signed div: A=−7 (0xFFFFFFF9), B=2, op=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu of the same operands → LO=0x7FFFFFFC, HI=1.
- Edge cases:
  - div by zero after mtlo 0x1234 and mthi 0x5678 (each visible next cycle) → busy 10 cycles, HI=0x5678, LO=0x1234 unchanged.
  - div 0x80000000 / −1 → LO=0x80000000, HI=0.
- Start while busy: mult in flight, start=1 op=4 A=0xAAAA mid-run → HI ends with the product, not 0xAAAA. A second start at edge T0+N+1 is accepted.

Source files
------------

// File: rtl/ex_mdu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ex_mdu : MIPS EX-stage multiply/divide unit holding architectural HI/LO
// Revision: 1.0
// ============================================================================
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [1:0]  op_r;
  logic [31:0] a_r, b_r;
  logic [31:0] hi_n, lo_n;
  logic        accept;

  logic        sgn, is_div;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [63:0] prod;

  // Even ops (mult/div) are signed; op bit 1 selects the divider.
  assign sgn    = ~op_r[0];
  assign is_div = op_r[1];

  assign prod = sgn ? ({{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r})
                    : ({32'd0, a_r} * {32'd0, b_r});

  // Signed division on magnitudes: truncates toward zero, remainder follows
  // the dividend, and 0x80000000 / -1 naturally wraps to 0x80000000 rem 0.
  assign a_mag = (sgn && a_r[31]) ? (~a_r + 32'd1) : a_r;
  assign b_mag = (sgn && b_r[31]) ? (~b_r + 32'd1) : b_r;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quot  = (sgn && (a_r[31] ^ b_r[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = (sgn && a_r[31]) ? (~r_mag + 32'd1) : r_mag;

  assign busy = (state == RUN);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = HI;
    lo_n    = LO;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            accept  = 1'b1;
            state_n = RUN;
            cnt_n   = op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
          end else if (op == 3'd4) begin
            hi_n = A;
          end else if (op == 3'd5) begin
            lo_n = A;
          end
        end
      end
      RUN: begin
        if (cnt > 5'd1) begin
          cnt_n = cnt - 5'd1;
        end else begin
          state_n = IDLE;
          cnt_n   = 5'd0;
          if (!is_div) begin
            hi_n = prod[63:32];
            lo_n = prod[31:0];
          end else if (b_r != 32'd0) begin
            hi_n = rem;
            lo_n = quot;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      op_r  <= 2'd0;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      HI    <= hi_n;
      LO    <= lo_n;
      if (accept) begin
        op_r <= op[1:0];
        a_r  <= A;
        b_r  <= B;
      end
    end
  end

endmodule
`default_nettype wire
